cd_scan_ctrl: RTL and testbench
===============================

Name: cd_scan_ctrl

Overview:
- Scan sequencer and requester arbiter for the colour-sensor frequency-counting datapath.
- Shares one photodiode sensor and its external cs_out edge counter between two requesters (e.g. pickup unit, path unit) using round-robin arbitration.
- For each granted request it sequences filter select, settle, gated count window and capture for green, red, then blue.
- It then classifies the colour and returns the result to the winning requester with a one-cycle ack.

Parameters:
- SETTLE_CYCLES, 20, cycles after a filter change before counting starts; legal range 1 or more.
- WINDOW_CYCLES, 500, cycles cnt_en is held high per channel; legal range 1 or more.
- CNT_W, 16, width of the edge count and the latched channel counts.
- MIN_COUNT, 1, minimum per-channel count for a valid classification.

Ports:
- clk_1MHz  in  1  system clock, 1 MHz.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  level scan requests; bit0 = requester 0, bit1 = requester 1; held until ack.
- ack  out  2  one-cycle, one-hot pulse to the served requester; color is valid in the same cycle.
- color  out  3  0 none/invalid, 1 red, 2 green, 3 blue; holds until the next decision.
- filter  out  2  S2S3 select: red 00, blue 01, clear 10, green 11.
- cnt_clr  out  1  synchronous clear of the external edge counter.
- cnt_en  out  1  gate for the external edge counter.
- cnt_val  in  CNT_W  external edge counter value.
- busy  out  1  high in every state except IDLE.
- red_cnt, green_cnt, blue_cnt  out  CNT_W each  latched per-channel counts from the last scan.

Behaviour:
- Reset values (asynchronous, active-high): state IDLE, filter 10, color 0, ack 00, cnt_clr 0, cnt_en 0, busy 0, all channel counts 0, round-robin pointer favours requester 0.
- States and transitions: IDLE -> SETTLE -> MEASURE -> CAPTURE, repeated per channel in the order green, red, blue; then DECIDE -> REPLY -> IDLE.
- IDLE:
  - filter = 10.
  - Sample req; if nonzero, grant per round-robin and go to SETTLE.
  - Round-robin rule: when both requests are high, grant the requester not served last.
- SETTLE:
  - filter = current channel encoding.
  - cnt_clr high on the first SETTLE cycle only; cnt_en low.
  - Stays exactly SETTLE_CYCLES cycles.
- MEASURE: cnt_en high for exactly WINDOW_CYCLES cycles; cnt_clr low.
- CAPTURE:
  - One cycle, cnt_en low.
  - Latch cnt_val into the current channel register.
  - Go to the next channel's SETTLE, or to DECIDE after blue.
- DECIDE (one cycle):
  - Any channel count below MIN_COUNT -> color 0.
  - Else red if red >= green and red >= blue.
  - Else green if green > blue.
  - Else blue.
  - Tie rules: red wins any tie involving red; a green/blue tie gives blue.
  - Comparisons are unsigned, CNT_W bits.
- REPLY (one cycle):
  - ack[grant] = 1 only if req[grant] is still high; otherwise no ack, but color is still updated.
  - Update the round-robin pointer; return to IDLE.
- Latency: req sampled high in IDLE at cycle 0 -> ack at cycle 1 + 3*(SETTLE_CYCLES + WINDOW_CYCLES + 1) + 1. Defaults give 1565.
- Boundary conditions:
  - A request arriving mid-scan waits; no preemption.
  - A granted requester dropping req mid-scan: the scan completes and ack is suppressed.
  - A requester holding req after its ack is treated as a new request; the other requester wins if pending.
  - Simultaneous req rising on both bits in IDLE: round-robin decides.
  - cnt_val at CNT_W all-ones is used as is; saturation is the counter's responsibility.
  - The external counter must reflect all edges counted while cnt_en was high by the CAPTURE cycle.
  - Reset mid-scan: immediate return to reset values; partially captured counts are zeroed; no ack.
  - ack is never asserted on both bits at once.

Decomposition:
- Shared package cd_pkg holds:
  - filter encodings FILT_RED/BLUE/CLEAR/GREEN;
  - color codes COL_NONE/RED/GREEN/BLUE;
  - the state typedef.
- Sub-module cd_rr_arbiter: 2-way round-robin with a last-grant pointer. Inputs req, update; output one-hot grant.

Test Plan:
- SETTLE=2, WINDOW=10, req=01 at cycle 0, counter model returns R=40, G=20, B=10 -> ack=01 at cycle 41, color=1, red_cnt=40; cnt_en high for exactly 10 cycles per channel, filter sequence 11, 00, 01.
- Counts R=15, G=30, B=30 -> color=3; counts R=30, G=30, B=5 -> color=1 (tie rules).
- Counts R=0, G=50, B=50 -> color=0; ack still pulsed.
- req=11 in IDLE after reset -> requester 0 served first, then requester 1; third request with req=11 -> requester 0 served again.
- req[0] dropped at cycle 20 of a scan -> no ack at cycle 41, color updated, busy falls at cycle 42.
- reset asserted at cycle 25 of a scan -> filter=10, cnt_en=0, busy=0, all counts 0 in the same cycle; next req starts a fresh scan with green first.

Source files
------------

// File: rtl/cd_pkg.sv
// Shared encodings for the colour-sensor scan controller: filter selects,
// colour codes, channel indices and the sequencer state type.
package cd_pkg;

    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;
    localparam logic [1:0] FILT_GREEN = 2'b11;

    localparam logic [2:0] COL_NONE  = 3'd0;
    localparam logic [2:0] COL_RED   = 3'd1;
    localparam logic [2:0] COL_GREEN = 3'd2;
    localparam logic [2:0] COL_BLUE  = 3'd3;

    // Channels are scanned in index order: green, red, blue.
    localparam logic [1:0] CH_GREEN = 2'd0;
    localparam logic [1:0] CH_RED   = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_CAPTURE,
        ST_DECIDE,
        ST_REPLY
    } state_t;

    function automatic logic [1:0] chan_filter(input logic [1:0] ch);
        case (ch)
            CH_GREEN: chan_filter = FILT_GREEN;
            CH_RED:   chan_filter = FILT_RED;
            default:  chan_filter = FILT_BLUE;
        endcase
    endfunction

endpackage

// File: rtl/cd_rr_arbiter.sv
// Two-way round-robin arbiter: on contention the requester not served last
// wins. The pointer moves only when the controller reports a completed service.
module cd_rr_arbiter (
    input  logic       clk_1MHz,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic [1:0] served,
    output logic [1:0] grant
);

    // 1 means requester 1 was served most recently; reset favours requester 0.
    logic last_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (update && (|served)) begin
            last_reg <= served[1];
        end
    end

endmodule

// File: rtl/cd_scan_ctrl.sv
// Scan sequencer for the shared colour sensor: arbitrates two requesters, runs
// settle/count/capture for green, red and blue, classifies and acknowledges.
module cd_scan_ctrl #(
    parameter int SETTLE_CYCLES = 20,
    parameter int WINDOW_CYCLES = 500,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 1
) (
    input  logic             clk_1MHz,
    input  logic             reset,
    input  logic [1:0]       req,
    output logic [1:0]       ack,
    output logic [2:0]       color,
    output logic [1:0]       filter,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             busy,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt
);
    import cd_pkg::*;

    localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_COUNT);

    state_t           state_reg, state_next;
    logic [1:0]       chan_reg, chan_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [1:0]       grant_reg, grant_next;
    logic [2:0]       color_reg, color_next;
    logic [1:0]       arb_grant;
    logic             arb_update;
    logic             capture;

    cd_rr_arbiter u_arb (
        .clk_1MHz (clk_1MHz),
        .reset    (reset),
        .req      (req),
        .update   (arb_update),
        .served   (grant_reg),
        .grant    (arb_grant)
    );

    // Red wins any tie involving red; a green/blue tie goes to blue.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
        if ((r < MIN_CNT) || (g < MIN_CNT) || (b < MIN_CNT)) return COL_NONE;
        if ((r >= g) && (r >= b)) return COL_RED;
        if (g > b) return COL_GREEN;
        return COL_BLUE;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk_1MHz or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (capture && (chan_reg == 2'(gi))) begin
                cnt_reg <= cnt_val;
            end
        end
    end

    assign green_cnt = g_chan[0].cnt_reg;
    assign red_cnt   = g_chan[1].cnt_reg;
    assign blue_cnt  = g_chan[2].cnt_reg;
    assign color     = color_reg;

    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            chan_reg  <= CH_GREEN;
            timer_reg <= '0;
            grant_reg <= 2'b00;
            color_reg <= COL_NONE;
        end else begin
            state_reg <= state_next;
            chan_reg  <= chan_next;
            timer_reg <= timer_next;
            grant_reg <= grant_next;
            color_reg <= color_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        chan_next  = chan_reg;
        timer_next = timer_reg;
        grant_next = grant_reg;
        color_next = color_reg;
        filter     = FILT_CLEAR;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        ack        = 2'b00;
        busy       = 1'b1;
        arb_update = 1'b0;
        capture    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    grant_next = arb_grant;
                    chan_next  = CH_GREEN;
                    timer_next = '0;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                filter  = chan_filter(chan_reg);
                cnt_clr = (timer_reg == '0);
                if (timer_reg == SETTLE_LAST) begin
                    timer_next = '0;
                    state_next = ST_MEASURE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_MEASURE: begin
                filter = chan_filter(chan_reg);
                cnt_en = 1'b1;
                if (timer_reg == WINDOW_LAST) begin
                    timer_next = '0;
                    state_next = ST_CAPTURE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_CAPTURE: begin
                filter  = chan_filter(chan_reg);
                capture = 1'b1;
                if (chan_reg == CH_BLUE) begin
                    state_next = ST_DECIDE;
                end else begin
                    chan_next  = chan_reg + 2'd1;
                    timer_next = '0;
                    state_next = ST_SETTLE;
                end
            end
            ST_DECIDE: begin
                color_next = classify(red_cnt, green_cnt, blue_cnt);
                state_next = ST_REPLY;
            end
            ST_REPLY: begin
                // A requester that withdrew mid-scan gets no ack.
                ack        = grant_reg & req;
                arb_update = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cd_scan_ctrl.sv
// Bench for cd_scan_ctrl: directed and random scans against a behavioural
// counter, round-robin and colour model.
`timescale 1ns/1ps
module tb_cd_scan_ctrl;

    localparam int S   = 2;
    localparam int W   = 10;
    localparam int CW  = 16;
    localparam int LAT = 1 + 3 * (S + W + 1) + 1;

    logic          clk_1MHz = 1'b0;
    logic          reset    = 1'b1;
    logic [1:0]    req      = 2'b00;
    logic [1:0]    ack;
    logic [2:0]    color;
    logic [1:0]    filter;
    logic          cnt_clr;
    logic          cnt_en;
    logic [CW-1:0] cnt_val;
    logic          busy;
    logic [CW-1:0] red_cnt, green_cnt, blue_cnt;

    int total = 0;
    int bad   = 0;

    // Expected scene counts indexed by filter code (00 red, 01 blue, 11 green).
    logic [CW-1:0] tgt [4];
    int            en_cnt    = 0;
    int            last_srv  = 1;
    logic [2:0]    exp_color = 3'd0;

    cd_scan_ctrl #(
        .SETTLE_CYCLES (S),
        .WINDOW_CYCLES (W),
        .CNT_W         (CW),
        .MIN_COUNT     (1)
    ) dut (
        .clk_1MHz  (clk_1MHz),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .color     (color),
        .filter    (filter),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .cnt_val   (cnt_val),
        .busy      (busy),
        .red_cnt   (red_cnt),
        .green_cnt (green_cnt),
        .blue_cnt  (blue_cnt)
    );

    always #500 clk_1MHz = ~clk_1MHz;

    // External counter: reports the scene count only after exactly W gated cycles since clear.
    always @(posedge clk_1MHz) begin
        if (cnt_clr) en_cnt <= 0;
        else if (cnt_en) en_cnt <= en_cnt + 1;
    end
    assign cnt_val = (en_cnt == W) ? tgt[filter] : 16'h1234;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_color(input int r, input int g, input int b);
        int m;
        if (r < 1 || g < 1 || b < 1) return 3'd0;
        m = r;
        if (g > m) m = g;
        if (b > m) m = b;
        if (r == m) return 3'd1;
        if (b == m) return 3'd3;
        return 3'd2;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_filter"}, filter, 2'b10);
        check({tag, "_cnt_en"}, cnt_en, 1'b0);
        check({tag, "_cnt_clr"}, cnt_clr, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ack"}, ack, 2'b00);
        check({tag, "_color"}, color, 3'd0);
        check({tag, "_red"}, red_cnt, 0);
        check({tag, "_green"}, green_cnt, 0);
        check({tag, "_blue"}, blue_cnt, 0);
    endtask

    // Called at a negedge with the DUT idle and req nonzero (that cycle is cycle 0).
    task automatic scan(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b,
                        input int drop_at, input int rst_at, input bit hold);
        int         win;
        logic [1:0] win_oh;
        bit         dropped = 0;
        bit         prev_en = 0;
        int         en_n = 0;
        int         clr_n = 0;
        logic [1:0] fseq [$];
        win    = (req == 2'b11) ? (1 - last_srv) : (req[1] ? 1 : 0);
        win_oh = 2'b01 << win;
        tgt[0] = r; tgt[1] = b; tgt[2] = 16'h1234; tgt[3] = g;
        check("color_held", color, exp_color);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk_1MHz);
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                check_reset_values("midscan_reset");
                req       = 2'b00;
                last_srv  = 1;
                exp_color = 3'd0;
                @(negedge clk_1MHz);
                reset = 1'b0;
                return;
            end
            if (cnt_en) begin
                en_n++;
                if (!prev_en) fseq.push_back(filter);
            end
            prev_en = cnt_en;
            if (cnt_clr) clr_n++;
            check("ack", ack, (k == LAT && !dropped) ? win_oh : 2'b00);
            if (k <= LAT) check("busy_high", busy, 1'b1);
            if (k == LAT) begin
                exp_color = ref_color(r, g, b);
                check("color", color, exp_color);
                check("red_cnt", red_cnt, r);
                check("green_cnt", green_cnt, g);
                check("blue_cnt", blue_cnt, b);
                last_srv = win;
                if (!dropped && !hold) req[win] = 1'b0;
            end
            if (k == drop_at) begin
                req[win] = 1'b0;
                dropped  = 1;
            end
        end
        check("busy_low", busy, 1'b0);
        check("idle_filter", filter, 2'b10);
        check("en_cycles", en_n, 3 * W);
        check("clr_cycles", clr_n, 3);
        check("window_count", fseq.size(), 3);
        if (fseq.size() == 3) begin
            check("filter_g", fseq[0], 2'b11);
            check("filter_r", fseq[1], 2'b00);
            check("filter_b", fseq[2], 2'b01);
        end
        $display("scan win=%0d rgb=%0d/%0d/%0d color=%0d dropped=%0d", win, r, g, b, color, dropped);
    endtask

    function automatic logic [CW-1:0] pick(input logic [CW-1:0] base);
        int sel;
        sel = $urandom_range(0, 11);
        if (sel < 4) return base;
        if (sel == 4) return '0;
        if (sel == 5) return 16'hFFFF;
        return CW'($urandom_range(1, 4000));
    endfunction

    initial begin
        logic [CW-1:0] base;
        int            drop;
        for (int i = 0; i < 4; i++) tgt[i] = '0;
        repeat (2) @(negedge clk_1MHz);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk_1MHz);

        req = 2'b01; scan(16'd40, 16'd20, 16'd10, 0, 0, 0);
        req = 2'b01; scan(16'd15, 16'd30, 16'd30, 0, 0, 0);
        req = 2'b01; scan(16'd30, 16'd30, 16'd5, 0, 0, 0);
        req = 2'b01; scan(16'd0, 16'd50, 16'd50, 0, 0, 0);
        req = 2'b10; scan(16'hFFFF, 16'd3, 16'd3, 0, 0, 0);

        reset = 1'b1;
        @(negedge clk_1MHz);
        reset = 1'b0;
        last_srv  = 1;
        exp_color = 3'd0;
        @(negedge clk_1MHz);
        req = 2'b11; scan(16'd7, 16'd9, 16'd8, 0, 0, 0);
        scan(16'd100, 16'd200, 16'd300, 0, 0, 0);
        req = 2'b11; scan(16'd5, 16'd6, 16'd6, 0, 0, 0);
        scan(16'd9, 16'd9, 16'd9, 0, 0, 0);

        req = 2'b01; scan(16'd40, 16'd20, 16'd10, 20, 0, 0);
        req = 2'b01; scan(16'd40, 16'd20, 16'd10, 0, 25, 0);
        req = 2'b01; scan(16'd11, 16'd22, 16'd33, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            if (req == 2'b00) req = 2'($urandom_range(1, 3));
            base = CW'($urandom_range(1, 4000));
            drop = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 35) : 0;
            scan(pick(base), pick(base), pick(base), drop, 0, $urandom_range(0, 3) == 0);
        end
        req = 2'b00;
        @(negedge clk_1MHz);
        check("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
